// File: rtl/resync_fifo_mem.sv
// Storage array for resync_fifo_nonsynt.
// Provides one synchronous write port and one asynchronous read port.
module resync_fifo_mem #(
  parameter int width     = 32,
  parameter int log_depth = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [log_depth-1:0] waddr,
  input  logic [width-1:0]     wdata,
  input  logic [log_depth-1:0] raddr,
  output logic [width-1:0]     rdata
);

  localparam int DEPTH = 2 ** log_depth;

  logic [width-1:0] mem [DEPTH];

  // NOTE: the array has no reset. The top masks data_rd while the FIFO is
  // empty, so stale entries can never reach the output.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/resync_fifo_nonsynt.sv
// Single-clock show-ahead FIFO with occupancy-derived status flags.
// Define RESYNC_FIFO_ERR_CHECK_EN to stop simulation on any overflow or underflow attempt.
module resync_fifo_nonsynt #(
  parameter int width     = 32,
  parameter int log_depth = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             val_wr,
  input  logic [width-1:0] data_wr,
  input  logic             val_rd,
  output logic [width-1:0] data_rd,
  output logic             empty_rd,
  output logic             almost_empty_rd,
  output logic             full_wr
);

  localparam int DEPTH = 2 ** log_depth;
  localparam logic [log_depth:0] cnt_full = (log_depth + 1)'(DEPTH);
  localparam logic [log_depth:0] cnt_one  = (log_depth + 1)'(1);

  logic [log_depth-1:0] wr_ptr;
  logic [log_depth-1:0] rd_ptr;
  logic [log_depth:0]   count;
  logic [width-1:0]     mem_rdata;
  logic                 wr_acc;
  logic                 rd_acc;

  assign empty_rd        = (count == '0);
  assign almost_empty_rd = (count == cnt_one);
  assign full_wr         = (count == cnt_full);

  // Acceptance is decided from the flags before the edge, so a read never
  // frees space for a same-cycle write, and a write never feeds a same-cycle read.
  assign wr_acc = val_wr && !full_wr;
  assign rd_acc = val_rd && !empty_rd;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values that were present before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + log_depth'(1);
      if (rd_acc) rd_ptr <= rd_ptr + log_depth'(1);
      if (wr_acc && !rd_acc)      count <= count + cnt_one;
      else if (rd_acc && !wr_acc) count <= count - cnt_one;
    end
  end

  resync_fifo_mem #(
    .width     (width),
    .log_depth (log_depth)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_wr),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  assign data_rd = empty_rd ? '0 : mem_rdata;

`ifdef RESYNC_FIFO_ERR_CHECK_EN
  always @(posedge clk) begin
    if (!rst && val_wr && full_wr) begin
      $error("%m: write attempted while FIFO full");
      $finish;
    end
    if (!rst && val_rd && empty_rd) begin
      $error("%m: read attempted while FIFO empty");
      $finish;
    end
  end
`else
  // Overflow and underflow attempts are dropped silently by wr_acc and rd_acc.
`endif

endmodule

// File: tb/tb_resync_fifo_nonsynt.sv
// Directed self-checking bench for resync_fifo_nonsynt (width=32, log_depth=3).
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_resync_fifo_nonsynt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        val_wr = 1'b0;
  logic [31:0] data_wr = '0;
  logic        val_rd = 1'b0;
  logic [31:0] data_rd;
  logic        empty_rd;
  logic        almost_empty_rd;
  logic        full_wr;

  int errors = 0;
  int checks = 0;

  resync_fifo_nonsynt #(
    .width     (32),
    .log_depth (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .val_wr          (val_wr),
    .data_wr         (data_wr),
    .val_rd          (val_rd),
    .data_rd         (data_rd),
    .empty_rd        (empty_rd),
    .almost_empty_rd (almost_empty_rd),
    .full_wr         (full_wr)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string name, input logic e, input logic ae, input logic f);
    checks++;
    if ({empty_rd, almost_empty_rd, full_wr} !== {e, ae, f}) begin
      errors++;
      $display("FAIL %s flags: got empty=%b almost=%b full=%b, want empty=%b almost=%b full=%b",
               name, empty_rd, almost_empty_rd, full_wr, e, ae, f);
    end
  endtask

  task automatic chk_data(input string name, input logic [31:0] exp);
    checks++;
    if (data_rd !== exp) begin
      errors++;
      $display("FAIL %s data_rd: got %h, want %h", name, data_rd, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    chk_flags("reset", 1'b1, 1'b0, 1'b0);
    chk_data("reset", 32'h0);
    step();
    rst = 1'b0;
    step();
    chk_flags("reset_release", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    val_wr = 1'b1; data_wr = 32'hA5A5_A5A5;
    step();
    val_wr = 1'b0;
    chk_flags("single_write", 1'b0, 1'b1, 1'b0);
    chk_data("single_write", 32'hA5A5_A5A5);
    val_rd = 1'b1;
    step();
    val_rd = 1'b0;
    chk_flags("single_pop", 1'b1, 1'b0, 1'b0);
    chk_data("single_pop", 32'h0);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      val_wr = 1'b1; data_wr = 32'(i);
      step();
    end
    val_wr = 1'b0;
    chk_flags("fill_8", 1'b0, 1'b0, 1'b1);
    chk_data("fill_head", 32'h1);
    // Write while full alone: dropped.
    val_wr = 1'b1; data_wr = 32'h9;
    step();
    chk_flags("fill_overflow", 1'b0, 1'b0, 1'b1);
    chk_data("fill_overflow_head", 32'h1);
    // Write while full together with a read: read accepted, write dropped.
    val_rd = 1'b1; data_wr = 32'h99;
    step();
    val_wr = 1'b0;
    chk_flags("full_rd_wr", 1'b0, 1'b0, 1'b0);
    chk_data("full_rd_wr_head", 32'h2);
    for (int i = 2; i <= 8; i++) begin
      chk_data($sformatf("drain_%0d", i), 32'(i));
      step();
    end
    val_rd = 1'b0;
    chk_flags("drain_empty", 1'b1, 1'b0, 1'b0);
    chk_data("drain_empty", 32'h0);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) begin
      val_wr = 1'b1; data_wr = 32'h10 + 32'(i);
      step();
    end
    chk_flags("sim_occ3", 1'b0, 1'b0, 1'b0);
    val_rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_wr = 32'h13 + 32'(i);
      chk_data($sformatf("sim_head_%0d", i), 32'h10 + 32'(i));
      step();
      chk_flags($sformatf("sim_flags_%0d", i), 1'b0, 1'b0, 1'b0);
    end
    val_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_data($sformatf("sim_drain_%0d", i), 32'h1A + 32'(i));
      step();
    end
    val_rd = 1'b0;
    chk_flags("sim_end", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_underflow();
    val_rd = 1'b1;
    step();
    chk_flags("underflow", 1'b1, 1'b0, 1'b0);
    chk_data("underflow", 32'h0);
    // Read while empty together with a write: write accepted, read ignored.
    val_wr = 1'b1; data_wr = 32'hCAFE_0001;
    step();
    val_wr = 1'b0; val_rd = 1'b0;
    chk_flags("empty_rd_wr", 1'b0, 1'b1, 1'b0);
    chk_data("empty_rd_wr", 32'hCAFE_0001);
    val_rd = 1'b1;
    step();
    val_rd = 1'b0;
    chk_flags("underflow_cleanup", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      val_wr = 1'b1; data_wr = 32'h50 + 32'(i);
      step();
    end
    val_wr = 1'b0;
    chk_data("mid_head", 32'h50);
    rst = 1'b1;
    #1;
    chk_flags("mid_async_rst", 1'b1, 1'b0, 1'b0);
    chk_data("mid_async_rst", 32'h0);
    // Strobes during reset are ignored across an edge.
    val_wr = 1'b1; data_wr = 32'h77; val_rd = 1'b1;
    step();
    chk_flags("mid_rst_held", 1'b1, 1'b0, 1'b0);
    val_wr = 1'b0; val_rd = 1'b0;
    rst = 1'b0;
    step();
    val_wr = 1'b1; data_wr = 32'h1;
    step();
    val_wr = 1'b0;
    chk_flags("post_rst_write", 1'b0, 1'b1, 1'b0);
    chk_data("post_rst_write", 32'h1);
    val_rd = 1'b1;
    step();
    val_rd = 1'b0;
    chk_flags("post_rst_pop", 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_simultaneous();
    test_underflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish within 50000 ns");
    $fatal(1, "timeout");
  end

endmodule
